// File: rtl/lru_ch_arbiter.sv
// Least-recently-used channel arbiter: picks the oldest eligible channel, holds the
// grant until the queue selects, the request vanishes, or a timeout expires.
module lru_ch_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p_lru_join_ch,
  input  logic [3:0] p_ch_mask,
  input  logic       p_arb_rdy,
  input  logic       p_sel_val,
  output logic       p_arb_val,
  output logic [1:0] p_arb_ch,
  output logic       p_arb_drop,
  output logic       p_lru_err
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [3:0][1:0] ord;      // ord[0] least recent .. ord[3] most recent
  logic [3:0]      cnt;

  logic [3:0]      cand;
  logic            found;
  logic [1:0]      winner;
  logic [1:0]      pos;
  logic [3:0][1:0] ord_upd;
  logic [3:0]      seen;
  logic            perm_ok;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cand   = p_lru_join_ch & ~p_ch_mask;
    found  = 1'b0;
    winner = ord[0];
    // Scan from MRU down so the least-recent eligible slot is the one left standing.
    for (int k = 3; k >= 0; k--) begin
      if (cand[ord[k]]) begin
        found  = 1'b1;
        winner = ord[k];
      end
    end

    pos = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (ord[k] == p_arb_ch) pos = 2'(k);
    end

    ord_upd = ord;
    for (int k = 0; k < 3; k++) begin
      if (k >= int'(pos)) ord_upd[k] = ord[k+1];
    end
    ord_upd[3] = p_arb_ch;

    seen = 4'b0000;
    for (int k = 0; k < 4; k++) seen[ord[k]] = 1'b1;
    perm_ok = &seen;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader
  // of a register sees its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ord        <= {2'd3, 2'd2, 2'd1, 2'd0};
      cnt        <= '0;
      p_arb_val  <= 1'b0;
      p_arb_ch   <= 2'd0;
      p_arb_drop <= 1'b0;
      p_lru_err  <= 1'b0;
    end else begin
      p_arb_drop <= 1'b0;
      if (!perm_ok) p_lru_err <= 1'b1;

      case (state)
        IDLE: begin
          if (found && p_arb_rdy) begin
            state     <= GRANT;
            p_arb_val <= 1'b1;
            p_arb_ch  <= winner;
            cnt       <= '0;
          end
        end
        GRANT: begin
          // Selection beats request withdrawal, which beats the timeout.
          if (p_sel_val) begin
            state     <= IDLE;
            p_arb_val <= 1'b0;
            ord       <= ord_upd;
          end else if (!p_lru_join_ch[p_arb_ch] || cnt == 4'(TIMEOUT - 1)) begin
            state      <= IDLE;
            p_arb_val  <= 1'b0;
            p_arb_drop <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lru_ch_arbiter.sv
// Self-checking bench for lru_ch_arbiter: directed scenarios plus a randomized run
// compared against a queue-based LRU model.
module tb_lru_ch_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lru_join;
  logic [3:0] mask;
  logic       rdy;
  logic       sel;
  logic       arb_val;
  logic [1:0] arb_ch;
  logic       arb_drop;
  logic       lru_err;

  int checks = 0;
  int errors = 0;

  lru_ch_arbiter #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .p_lru_join_ch (lru_join),
    .p_ch_mask     (mask),
    .p_arb_rdy     (rdy),
    .p_sel_val     (sel),
    .p_arb_val     (arb_val),
    .p_arb_ch      (arb_ch),
    .p_arb_drop    (arb_drop),
    .p_lru_err     (lru_err)
  );

  always #5 clk = ~clk;

  // Reference model: LRU order is a queue, front = least recent.
  int   lru_q[$];
  bit   m_grant;
  int   m_ch;
  bit   m_drop;
  int   m_idle_cnt;

  function automatic logic [7:0] model_ord();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[2*i +: 2] = 2'(lru_q[i]);
    return v;
  endfunction

  task automatic tick();
    logic [3:0] c;
    if (rst) begin
      m_grant = 0; m_ch = 0; m_drop = 0; m_idle_cnt = 0;
      lru_q = '{0, 1, 2, 3};
    end else begin
      m_drop = 0;
      if (m_grant) begin
        if (sel) begin
          foreach (lru_q[i]) if (lru_q[i] == m_ch) begin lru_q.delete(i); break; end
          lru_q.push_back(m_ch);
          m_grant = 0;
        end else if (!lru_join[m_ch]) begin
          m_grant = 0; m_drop = 1;
        end else if (m_idle_cnt + 1 == TO) begin
          m_grant = 0; m_drop = 1;
        end else begin
          m_idle_cnt++;
        end
      end else if (rdy) begin
        c = lru_join & ~mask;
        foreach (lru_q[i]) if (c[lru_q[i]]) begin
          m_grant = 1; m_ch = lru_q[i]; m_idle_cnt = 0; break;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; lru_join = 0; mask = 0; rdy = 0; sel = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({arb_val, arb_ch, arb_drop, lru_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got val=%b ch=%0d drop=%b err=%b exp all 0", arb_val, arb_ch, arb_drop, lru_err);
    end
    checks++;
    if (dut.ord !== 8'hE4) begin
      errors++;
      $display("FAIL reset_ord got=%h exp=e4", dut.ord);
    end
  endtask

  task automatic test_round_robin();
    int exp_ch[5] = '{0, 1, 2, 3, 0};
    do_reset();
    lru_join = 4'hF; rdy = 1; sel = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (arb_val !== 1'(i % 2)) begin
        errors++;
        $display("FAIL rr_val tick=%0d got=%b exp=%b", i, arb_val, 1'(i % 2));
      end
      if (i % 2 == 1) begin
        checks++;
        if (arb_ch !== 2'(exp_ch[(i-1)/2])) begin
          errors++;
          $display("FAIL rr_ch tick=%0d got=%0d exp=%0d", i, arb_ch, exp_ch[(i-1)/2]);
        end
      end
    end
  endtask

  task automatic test_masked();
    do_reset();
    lru_join = 4'b1010; mask = 4'b0010; rdy = 1; sel = 1;
    tick();
    checks++;
    if (arb_val !== 1'b1 || arb_ch !== 2'd3) begin
      errors++;
      $display("FAIL mask_grant got val=%b ch=%0d exp val=1 ch=3", arb_val, arb_ch);
    end
    lru_join = 0;
    tick();
    checks++;
    if (arb_val !== 1'b0 || dut.ord !== 8'hE4) begin
      errors++;
      $display("FAIL mask_ord got val=%b ord=%h exp val=0 ord=e4", arb_val, dut.ord);
    end
    mask = 0;
  endtask

  task automatic test_timeout();
    int high = 1;
    do_reset();
    lru_join = 4'b0100; rdy = 1; sel = 0;
    tick();
    checks++;
    if (arb_val !== 1'b1 || arb_ch !== 2'd2) begin
      errors++;
      $display("FAIL to_grant got val=%b ch=%0d exp val=1 ch=2", arb_val, arb_ch);
    end
    for (int i = 0; i < 20 && arb_val === 1'b1; i++) begin
      tick();
      if (arb_val === 1'b1) high++;
    end
    checks++;
    if (high != TO || arb_drop !== 1'b1) begin
      errors++;
      $display("FAIL to_len got high=%0d drop=%b exp high=%0d drop=1", high, arb_drop, TO);
    end
    tick();
    checks++;
    if (arb_drop !== 1'b0 || arb_val !== 1'b1 || arb_ch !== 2'd2) begin
      errors++;
      $display("FAIL to_regrant got drop=%b val=%b ch=%0d exp drop=0 val=1 ch=2", arb_drop, arb_val, arb_ch);
    end
    lru_join = 0; sel = 1;
    tick();
    sel = 0;
  endtask

  task automatic test_join_drop();
    do_reset();
    lru_join = 4'b0010; rdy = 1; sel = 0;
    tick();
    lru_join = 0;
    tick();
    checks++;
    if (arb_val !== 1'b0 || arb_drop !== 1'b1) begin
      errors++;
      $display("FAIL jd_drop got val=%b drop=%b exp val=0 drop=1", arb_val, arb_drop);
    end
    tick();
    checks++;
    if (arb_drop !== 1'b0 || dut.ord !== 8'hE4) begin
      errors++;
      $display("FAIL jd_pulse got drop=%b ord=%h exp drop=0 ord=e4", arb_drop, dut.ord);
    end
    lru_join = 4'b0010;
    tick();
    lru_join = 0; sel = 1;
    tick();
    checks++;
    if (arb_val !== 1'b0 || arb_drop !== 1'b0 || dut.ord !== 8'h78) begin
      errors++;
      $display("FAIL jd_sel got val=%b drop=%b ord=%h exp val=0 drop=0 ord=78", arb_val, arb_drop, dut.ord);
    end
    sel = 0;
  endtask

  task automatic test_reset_in_grant();
    do_reset();
    lru_join = 4'hF; rdy = 1; sel = 1;
    tick(); tick(); tick(); tick();
    lru_join = 4'b1000; sel = 0;
    tick();
    checks++;
    if (arb_val !== 1'b1 || arb_ch !== 2'd3) begin
      errors++;
      $display("FAIL rg_grant got val=%b ch=%0d exp val=1 ch=3", arb_val, arb_ch);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (arb_val !== 1'b0 || arb_ch !== 2'd0 || arb_drop !== 1'b0 || dut.ord !== 8'hE4) begin
      errors++;
      $display("FAIL rg_state got val=%b ch=%0d drop=%b ord=%h exp 0 0 0 e4", arb_val, arb_ch, arb_drop, dut.ord);
    end
  endtask

  task automatic test_lru_err();
    do_reset();
    checks++;
    if (lru_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got=%b exp=0", lru_err);
    end
    force dut.ord = 8'h00;
    tick();
    checks++;
    if (lru_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got=%b exp=1", lru_err);
    end
    release dut.ord;
    tick(); tick();
    checks++;
    if (lru_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b exp=1", lru_err);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (lru_err !== 1'b0 || dut.ord !== 8'hE4) begin
      errors++;
      $display("FAIL err_reset got err=%b ord=%h exp err=0 ord=e4", lru_err, dut.ord);
    end
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      thr      = (cyc < 200) ? 1 : (cyc < 400) ? 4 : 8;
      lru_join = (cyc < 200) ? 4'hF : 4'($urandom);
      mask     = 4'($urandom) & 4'($urandom);
      rdy      = ($urandom_range(0, 3) != 0);
      sel      = ($urandom_range(0, 9) < thr);
      rst      = ($urandom_range(0, 79) == 0);
      tick();
      checks++;
      if (arb_val !== m_grant || arb_ch !== 2'(m_ch) || arb_drop !== m_drop ||
          lru_err !== 1'b0 || dut.ord !== model_ord()) begin
        errors++;
        $display("FAIL rnd cyc=%0d got val=%b ch=%0d drop=%b err=%b ord=%h exp val=%b ch=%0d drop=%b err=0 ord=%h",
                 cyc, arb_val, arb_ch, arb_drop, lru_err, dut.ord, m_grant, m_ch, m_drop, model_ord());
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_masked();
    test_timeout();
    test_join_drop();
    test_reset_in_grant();
    test_lru_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lru_ch_arbiter.md
LRU_CH_ARBITER -- requirements
Module: lru_ch_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, the number of GRANT cycles without p_sel_val before the grant is dropped; legal range 2..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port p_lru_join_ch  input  4  per-channel "enabled request pending" flags from the request queue.
REQ-005 SHALL have port p_ch_mask  input  4  per-channel block; 1 = channel excluded from arbitration.
REQ-006 SHALL have port p_arb_rdy  input  1  downstream can accept a new grant.
REQ-007 SHALL have port p_sel_val  input  1  request queue selected an entry for the granted channel this cycle.
REQ-008 SHALL have port p_arb_val  output  1  grant valid, registered.
REQ-009 SHALL have port p_arb_ch  output  2  granted channel, registered.
REQ-010 SHALL have port p_arb_drop  output  1  one-cycle pulse: grant abandoned without selection.
REQ-011 SHALL have port p_lru_err  output  1  sticky LRU-state corruption flag.

Function
REQ-012 SHALL hold LRU order as four 2-bit slots ord[0] (least recent) .. ord[3] (most recent).
REQ-013 SHALL compute cand = p_lru_join_ch & ~p_ch_mask each cycle.
REQ-014 SHALL pick the winner as the first ord[k], k ascending, whose cand bit is set.
REQ-015 SHALL implement states IDLE and GRANT; p_arb_val = 1 exactly in GRANT.
REQ-016 IDLE -> GRANT when cand != 0 and p_arb_rdy = 1; winner registered into p_arb_ch at the same edge.
REQ-017 Otherwise SHALL stay in IDLE with p_arb_ch holding its last value.
REQ-018 SHALL keep p_arb_ch stable throughout GRANT.
REQ-019 In GRANT, p_sel_val = 1 SHALL cause at the next edge:
  - return to IDLE;
  - granted channel moved to ord[3], slots above its old position shifted down one;
  - other slot order unchanged.
REQ-020 In GRANT, p_sel_val = 0 with p_lru_join_ch[p_arb_ch] = 0 SHALL return to IDLE next edge with p_arb_drop = 1 for that one cycle and no LRU update.
REQ-021 SHALL count consecutive GRANT cycles without p_sel_val; count is cleared on GRANT entry.
REQ-022 When that count reaches TIMEOUT SHALL return to IDLE, pulse p_arb_drop and leave LRU unchanged.
REQ-023 On the same cycle, priority SHALL be p_sel_val > join-drop > timeout.
REQ-024 p_ch_mask changes during GRANT SHALL NOT affect the current grant.
REQ-025 Grant rate SHALL be at most one per two cycles, since IDLE always intervenes.
REQ-026 SHALL set p_lru_err at the next edge whenever ord is not a permutation of {0,1,2,3}; it holds until reset.
REQ-027 cand = 0 SHALL never produce a grant regardless of p_arb_rdy.

Reset
REQ-028 While rst = 1 SHALL force at each edge:
  - state IDLE;
  - ord = {0,1,2,3}, channel 0 least recent;
  - p_arb_val = 0, p_arb_ch = 0, p_arb_drop = 0, p_lru_err = 0;
  - timeout count = 0.
REQ-029 rst asserted during GRANT SHALL abandon the grant with no p_arb_drop pulse and no LRU update.
REQ-030 First grant is possible in the second cycle after rst deasserts.

Verification
REQ-031 After reset, join = 4'b1111, mask = 0, rdy = 1, p_sel_val asserted each GRANT cycle -> p_arb_ch sequence 0,1,2,3,0 on alternate cycles.
REQ-032 After reset, join = 4'b1010, mask = 4'b0010 -> grant ch3; with p_sel_val, final ord = {0,1,2,3}, ch3 moved to MRU and unchanged.
REQ-033 Grant ch2, then hold p_sel_val = 0 with join[2] = 1 -> p_arb_val high exactly TIMEOUT cycles (8), then p_arb_drop pulse, ch2 still winner next arbitration.
REQ-034 Grant ch1, then drop join[1] while p_sel_val = 0 -> IDLE next cycle, p_arb_drop = 1 for one cycle; same cycle with p_sel_val = 1 -> no drop, LRU updated.
REQ-035 Assert rst during GRANT on ch3 after two prior selections -> next cycle p_arb_val = 0, p_arb_ch = 0, ord = {0,1,2,3}, p_arb_drop = 0.
REQ-036 Force ord slot duplicate via backdoor -> p_lru_err = 1 next cycle and sticky until rst.
